// File: rtl/rob_if.sv
// Reorder-buffer bus bundling the dispatch, completion, retire and flush signals of rob_multiport.
// With ROB_PERF_CNT_EN defined the bundle also carries the perf_retired / perf_full_cycles counters.
interface rob_if #(
    parameter int DEPTH      = 32,
    parameter int DISPATCH_W = 3,
    parameter int COMPLETE_W = 3,
    parameter int RETIRE_W   = 3,
    parameter int DATA_W     = 64,
    parameter int XLEN       = 32
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic                         ext_flush;
    logic [DISPATCH_W-1:0]        dispatch_valid;
    logic [DISPATCH_W*DATA_W-1:0] dispatch_data;
    logic [DISPATCH_W-1:0]        dispatch_stall;
    logic [DISPATCH_W*IW-1:0]     dispatch_index;
    logic [COMPLETE_W-1:0]        complete_valid;
    logic [COMPLETE_W*IW-1:0]     complete_idx;
    logic [COMPLETE_W-1:0]        complete_mispred;
    logic [COMPLETE_W*XLEN-1:0]   complete_target;
    logic [RETIRE_W-1:0]          retire_valid;
    logic [RETIRE_W*DATA_W-1:0]   retire_data;
    logic [RETIRE_W*IW-1:0]       retire_idx;
    logic                         flush_valid;
    logic [XLEN-1:0]              flush_target;
    logic [CW-1:0]                occupancy;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]                  perf_retired;
    logic [31:0]                  perf_full_cycles;
`endif

    modport master (
        output ext_flush, dispatch_valid, dispatch_data,
        output complete_valid, complete_idx, complete_mispred, complete_target,
        input  dispatch_stall, dispatch_index, retire_valid, retire_data, retire_idx,
        input  flush_valid, flush_target, occupancy
`ifdef ROB_PERF_CNT_EN
        , input perf_retired, perf_full_cycles
`endif
    );

    modport slave (
        input  ext_flush, dispatch_valid, dispatch_data,
        input  complete_valid, complete_idx, complete_mispred, complete_target,
        output dispatch_stall, dispatch_index, retire_valid, retire_data, retire_idx,
        output flush_valid, flush_target, occupancy
`ifdef ROB_PERF_CNT_EN
        , output perf_retired, perf_full_cycles
`endif
    );
endinterface

// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: circular entry array with explicit occupancy count, in-order retire and mispredict flush.
// Optional feature macro: ROB_PERF_CNT_EN (saturating retired / dispatch-full cycle counters).
module rob_multiport_chk #(
    parameter int DISPATCH_W = 3
) (
    input logic                  clock,
    input logic                  reset_n,
    input logic [DISPATCH_W-1:0] dispatch_valid
);
    localparam logic [DISPATCH_W-1:0] LANE_ONE = {{(DISPATCH_W-1){1'b0}}, 1'b1};

    // Dispatch lanes must form a contiguous prefix starting at lane 0.
    a_contig: assert property (@(posedge clock) disable iff (!reset_n)
        ((dispatch_valid + LANE_ONE) & dispatch_valid) == '0);
endmodule

module rob_multiport #(
    parameter int DEPTH      = 32,
    parameter int DISPATCH_W = 3,
    parameter int COMPLETE_W = 3,
    parameter int RETIRE_W   = 3,
    parameter int DATA_W     = 64,
    parameter int XLEN       = 32
) (
    input logic  clock,
    input logic  reset_n,
    rob_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_F = (CW+1)'(DEPTH);

    logic [DEPTH-1:0]  ent_valid_r, ent_done_r, ent_mis_r;
    logic [XLEN-1:0]   ent_tgt_r  [DEPTH];
    logic [DATA_W-1:0] ent_data_r [DEPTH];
    logic [IW-1:0]     head_r, tail_r;
    logic [CW-1:0]     count_r;

    logic [RETIRE_W-1:0]          ret_valid_s;
    logic [RETIRE_W*IW-1:0]       ret_idx_s;
    logic [RETIRE_W*DATA_W-1:0]   ret_data_s;
    logic [CW-1:0]                nret_s, nacc_s;
    logic                         flush_s, clear_s;
    logic [XLEN-1:0]              flush_tgt_s;
    logic [CW:0]                  free_s;
    logic [DISPATCH_W-1:0]        stall_s, accept_s;
    logic [DISPATCH_W*IW-1:0]     didx_s;

    // Retire scan: in-order prefix of completed entries from head, closed by the first mispredict.
    always_comb begin
        logic          stop_s;
        logic [IW-1:0] slot_s;
        stop_s      = 1'b0;
        ret_valid_s = '0;
        ret_idx_s   = '0;
        ret_data_s  = '0;
        nret_s      = '0;
        flush_s     = 1'b0;
        flush_tgt_s = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            slot_s = head_r + IW'(k);
            if (!stop_s && (CW'(k) < count_r) && ent_done_r[slot_s]) begin
                ret_valid_s[k]                = 1'b1;
                ret_idx_s[k*IW +: IW]         = slot_s;
                ret_data_s[k*DATA_W +: DATA_W] = ent_data_r[slot_s];
                nret_s                        = nret_s + CW'(1);
                if (ent_mis_r[slot_s]) begin
                    stop_s      = 1'b1;
                    flush_s     = 1'b1;
                    flush_tgt_s = ent_tgt_r[slot_s];
                end else begin
                    stop_s = 1'b0;
                end
            end else begin
                stop_s = 1'b1;
            end
        end
    end

    // Dispatch credit counts slots freed by this cycle's retirement; a flush cycle refuses every lane.
    always_comb begin
        free_s   = DEPTH_F - {1'b0, count_r} + {1'b0, nret_s};
        stall_s  = '0;
        accept_s = '0;
        didx_s   = '0;
        nacc_s   = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (((CW+1)'(i) >= free_s) || flush_s) begin
                stall_s[i] = 1'b1;
            end else begin
                stall_s[i] = 1'b0;
            end
            if (bus.dispatch_valid[i] && !stall_s[i]) begin
                accept_s[i]           = 1'b1;
                didx_s[i*IW +: IW]    = tail_r + IW'(i);
                nacc_s                = nacc_s + CW'(1);
            end else begin
                accept_s[i] = 1'b0;
            end
        end
    end

    assign clear_s = bus.ext_flush | flush_s;

    // Entry array and pointers. Completion is applied before retire-clear and dispatch so a refilled slot starts clean.
    always_ff @(posedge clock) begin
        if (!reset_n || clear_s) begin
            ent_valid_r <= '0;
            ent_done_r  <= '0;
            ent_mis_r   <= '0;
            head_r      <= '0;
            tail_r      <= '0;
            count_r     <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                ent_tgt_r[d]  <= '0;
                ent_data_r[d] <= '0;
            end
        end else begin
            for (int p = 0; p < COMPLETE_W; p++) begin
                if (bus.complete_valid[p] && ent_valid_r[bus.complete_idx[p*IW +: IW]]) begin
                    ent_done_r[bus.complete_idx[p*IW +: IW]] <= 1'b1;
                    ent_mis_r[bus.complete_idx[p*IW +: IW]]  <= bus.complete_mispred[p];
                    ent_tgt_r[bus.complete_idx[p*IW +: IW]]  <= bus.complete_mispred[p] ?
                        bus.complete_target[p*XLEN +: XLEN] : {XLEN{1'b0}};
                end
            end
            for (int k = 0; k < RETIRE_W; k++) begin
                if (ret_valid_s[k]) begin
                    ent_valid_r[head_r + IW'(k)] <= 1'b0;
                    ent_done_r[head_r + IW'(k)]  <= 1'b0;
                end
            end
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (accept_s[i]) begin
                    ent_valid_r[tail_r + IW'(i)] <= 1'b1;
                    ent_done_r[tail_r + IW'(i)]  <= 1'b0;
                    ent_mis_r[tail_r + IW'(i)]   <= 1'b0;
                    ent_tgt_r[tail_r + IW'(i)]   <= '0;
                    ent_data_r[tail_r + IW'(i)]  <= bus.dispatch_data[i*DATA_W +: DATA_W];
                end
            end
            head_r  <= head_r + nret_s[IW-1:0];
            tail_r  <= tail_r + nacc_s[IW-1:0];
            count_r <= count_r + nacc_s - nret_s;
        end
    end

    assign bus.dispatch_stall = stall_s;
    assign bus.dispatch_index = didx_s;
    assign bus.retire_valid   = ret_valid_s;
    assign bus.retire_idx     = ret_idx_s;
    assign bus.retire_data    = ret_data_s;
    assign bus.flush_valid    = flush_s;
    assign bus.flush_target   = flush_tgt_s;
    assign bus.occupancy      = count_r;

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_ret_r, perf_full_r;

    // Saturating perf counters; ext_flush and mispredict flushes leave them untouched.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_ret_r  <= 32'd0;
            perf_full_r <= 32'd0;
        end else begin
            if (!bus.ext_flush) begin
                perf_ret_r <= (perf_ret_r > (32'hFFFF_FFFF - 32'(nret_s))) ? 32'hFFFF_FFFF : perf_ret_r + 32'(nret_s);
            end else begin
                perf_ret_r <= perf_ret_r;
            end
            if (bus.dispatch_valid[0] && stall_s[0] && (perf_full_r != 32'hFFFF_FFFF)) begin
                perf_full_r <= perf_full_r + 32'd1;
            end else begin
                perf_full_r <= perf_full_r;
            end
        end
    end

    assign bus.perf_retired     = perf_ret_r;
    assign bus.perf_full_cycles = perf_full_r;
`endif

    rob_multiport_chk #(.DISPATCH_W(DISPATCH_W)) u_chk (
        .clock          (clock),
        .reset_n        (reset_n),
        .dispatch_valid (bus.dispatch_valid)
    );
endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: directed scenarios and random traffic checked against a queue model of in-flight entries.
module tb_rob_multiport;
    localparam int DEPTH = 32, DISPATCH_W = 3, COMPLETE_W = 3, RETIRE_W = 3, DATA_W = 64, XLEN = 32;
    localparam int IW = $clog2(DEPTH), CW = $clog2(DEPTH + 1);

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    rob_if #(.DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W), .COMPLETE_W(COMPLETE_W),
             .RETIRE_W(RETIRE_W), .DATA_W(DATA_W), .XLEN(XLEN)) bus ();

    rob_multiport #(.DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W), .COMPLETE_W(COMPLETE_W),
                    .RETIRE_W(RETIRE_W), .DATA_W(DATA_W), .XLEN(XLEN)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int               slot;
        logic [DATA_W-1:0] data;
        bit               done;
        bit               mis;
        logic [XLEN-1:0]  tgt;
    } ent_t;

    ent_t q[$];
    int   m_tail, m_retired, m_full;
    int   checks = 0, failures = 0;

    logic [RETIRE_W-1:0]        e_rv;
    logic [RETIRE_W*IW-1:0]     e_ridx;
    logic [RETIRE_W*DATA_W-1:0] e_rdata;
    logic                       e_fl;
    logic [XLEN-1:0]            e_ft;
    logic [DISPATCH_W-1:0]      e_stall;
    logic [DISPATCH_W*IW-1:0]   e_didx;
    logic [CW-1:0]              e_occ;
    int                         e_nret, e_nacc;

    task automatic drive_idle();
        bus.ext_flush        = 1'b0;
        bus.dispatch_valid   = '0;
        bus.dispatch_data    = '0;
        bus.complete_valid   = '0;
        bus.complete_idx     = '0;
        bus.complete_mispred = '0;
        bus.complete_target  = '0;
    endtask

    task automatic rand_data();
        bus.dispatch_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // Expected outputs for the current inputs, from the in-order list of in-flight entries.
    task automatic model_eval();
        int free;
        #1;
        e_rv = '0; e_ridx = '0; e_rdata = '0; e_fl = 1'b0; e_ft = '0; e_nret = 0;
        for (int k = 0; k < RETIRE_W; k++) begin
            if (k >= q.size()) break;
            if (!q[k].done) break;
            e_rv[k] = 1'b1;
            e_ridx[k*IW +: IW] = IW'(q[k].slot);
            e_rdata[k*DATA_W +: DATA_W] = q[k].data;
            e_nret++;
            if (q[k].mis) begin
                e_fl = 1'b1;
                e_ft = q[k].tgt;
                break;
            end
        end
        free = DEPTH - q.size() + e_nret;
        e_stall = '0; e_didx = '0; e_nacc = 0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            e_stall[i] = (i >= free) || e_fl;
            if (bus.dispatch_valid[i] && !e_stall[i]) begin
                e_didx[i*IW +: IW] = IW'((m_tail + i) % DEPTH);
                e_nacc++;
            end
        end
        e_occ = CW'(q.size());
    endtask

    // Apply this cycle's edge to the model, then advance to the next falling edge.
    task automatic tick();
        if (bus.ext_flush || e_fl) begin
            q.delete();
            m_tail = 0;
        end else begin
            for (int p = 0; p < COMPLETE_W; p++) begin
                if (bus.complete_valid[p]) begin
                    for (int j = 0; j < q.size(); j++) begin
                        if (q[j].slot == int'(bus.complete_idx[p*IW +: IW])) begin
                            ent_t e;
                            e = q[j];
                            e.done = 1'b1;
                            e.mis  = bus.complete_mispred[p];
                            e.tgt  = e.mis ? bus.complete_target[p*XLEN +: XLEN] : '0;
                            q[j] = e;
                        end
                    end
                end
            end
            for (int k = 0; k < e_nret; k++) void'(q.pop_front());
            for (int i = 0; i < e_nacc; i++) begin
                ent_t e;
                e.slot = m_tail; e.data = bus.dispatch_data[i*DATA_W +: DATA_W];
                e.done = 1'b0; e.mis = 1'b0; e.tgt = '0;
                q.push_back(e);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        if (!bus.ext_flush) m_retired += e_nret;
        if (bus.dispatch_valid[0] && e_stall[0]) m_full++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic auto_complete();
        int p;
        p = 0;
        bus.complete_valid = '0; bus.complete_idx = '0; bus.complete_mispred = '0; bus.complete_target = '0;
        for (int j = 0; j < q.size() && p < COMPLETE_W; j++) begin
            if (!q[j].done) begin
                bus.complete_valid[p] = 1'b1;
                bus.complete_idx[p*IW +: IW] = IW'(q[j].slot);
                p++;
            end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        q.delete(); m_tail = 0; m_retired = 0; m_full = 0;
        model_eval();
        checks++; if (bus.occupancy !== 6'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", bus.occupancy); end
        checks++; if (bus.retire_valid !== 3'b000) begin failures++; $display("FAIL reset_retire_valid got=%b exp=000", bus.retire_valid); end
        checks++; if (bus.flush_valid !== 1'b0) begin failures++; $display("FAIL reset_flush_valid got=%b exp=0", bus.flush_valid); end
        checks++; if (bus.dispatch_stall !== 3'b000) begin failures++; $display("FAIL reset_stall got=%b exp=000", bus.dispatch_stall); end
    endtask

    task automatic test_fill();
        for (int c = 0; c < 13; c++) begin
            drive_idle();
            bus.dispatch_valid = 3'b111;
            rand_data();
            model_eval();
            checks++; if (bus.dispatch_index !== e_didx) begin failures++; $display("FAIL fill_index c=%0d got=%h exp=%h", c, bus.dispatch_index, e_didx); end
            checks++; if (bus.dispatch_stall !== e_stall) begin failures++; $display("FAIL fill_stall c=%0d got=%b exp=%b", c, bus.dispatch_stall, e_stall); end
            checks++; if (bus.occupancy !== e_occ) begin failures++; $display("FAIL fill_occupancy c=%0d got=%0d exp=%0d", c, bus.occupancy, e_occ); end
            if (c >= 11) begin
                checks++;
                if (bus.occupancy !== 6'd32 || bus.dispatch_stall !== 3'b111) begin
                    failures++; $display("FAIL fill_full c=%0d got occ=%0d stall=%b exp occ=32 stall=111", c, bus.occupancy, bus.dispatch_stall);
                end
            end
            tick();
        end
        drive_idle();
        model_eval();
`ifdef ROB_PERF_CNT_EN
        checks++; if (bus.perf_full_cycles !== 32'd2) begin failures++; $display("FAIL perf_full got=%0d exp=2", bus.perf_full_cycles); end
`endif
    endtask

    task automatic test_complete_retire();
        drive_idle();
        bus.complete_valid = 3'b111;
        bus.complete_idx   = {5'd2, 5'd1, 5'd0};
        model_eval();
        checks++; if (bus.retire_valid !== 3'b000) begin failures++; $display("FAIL cr_early_retire got=%b exp=000", bus.retire_valid); end
        tick();
        drive_idle();
        bus.dispatch_valid = 3'b111;
        rand_data();
        model_eval();
        checks++; if (bus.retire_valid !== 3'b111) begin failures++; $display("FAIL cr_retire_valid got=%b exp=111", bus.retire_valid); end
        checks++; if (bus.retire_idx !== {5'd2, 5'd1, 5'd0}) begin failures++; $display("FAIL cr_retire_idx got=%h exp=%h", bus.retire_idx, {5'd2, 5'd1, 5'd0}); end
        checks++; if (bus.retire_data !== e_rdata) begin failures++; $display("FAIL cr_retire_data got=%h exp=%h", bus.retire_data, e_rdata); end
        checks++; if (bus.dispatch_stall !== 3'b000) begin failures++; $display("FAIL cr_stall got=%b exp=000", bus.dispatch_stall); end
        checks++; if (bus.dispatch_index !== {5'd2, 5'd1, 5'd0}) begin failures++; $display("FAIL cr_dispatch_idx got=%h exp=%h", bus.dispatch_index, {5'd2, 5'd1, 5'd0}); end
        tick();
    endtask

    task automatic test_out_of_order();
        drive_idle();
        bus.complete_valid = 3'b001;
        bus.complete_idx   = {5'd0, 5'd0, 5'd4};
        model_eval();
        tick();
        drive_idle();
        bus.complete_valid = 3'b001;
        bus.complete_idx   = {5'd0, 5'd0, 5'd3};
        model_eval();
        checks++; if (bus.retire_valid !== 3'b000) begin failures++; $display("FAIL ooo_hold got=%b exp=000", bus.retire_valid); end
        tick();
        drive_idle();
        model_eval();
        checks++; if (bus.retire_valid !== 3'b011) begin failures++; $display("FAIL ooo_retire got=%b exp=011", bus.retire_valid); end
        checks++; if (bus.retire_idx !== {5'd0, 5'd4, 5'd3}) begin failures++; $display("FAIL ooo_idx got=%h exp=%h", bus.retire_idx, {5'd0, 5'd4, 5'd3}); end
        checks++; if (bus.dispatch_stall !== 3'b100) begin failures++; $display("FAIL ooo_stall got=%b exp=100", bus.dispatch_stall); end
        tick();
    endtask

    task automatic test_mispred();
        drive_idle();
        bus.ext_flush = 1'b1;
        model_eval();
        tick();
        for (int c = 0; c < 3; c++) begin
            drive_idle();
            bus.dispatch_valid = (c == 2) ? 3'b011 : 3'b111;
            rand_data();
            model_eval();
            tick();
        end
        drive_idle();
        bus.complete_valid = 3'b111;
        bus.complete_idx   = {5'd2, 5'd1, 5'd0};
        model_eval();
        checks++; if (bus.occupancy !== 6'd8) begin failures++; $display("FAIL mp_occupancy got=%0d exp=8", bus.occupancy); end
        tick();
        drive_idle();
        bus.complete_valid   = 3'b011;
        bus.complete_idx     = {5'd0, 5'd4, 5'd3};
        bus.complete_mispred = 3'b010;
        bus.complete_target  = {32'h0, 32'h0000_1000, 32'h0};
        model_eval();
        checks++; if (bus.retire_valid !== 3'b111 || bus.flush_valid !== 1'b0) begin
            failures++; $display("FAIL mp_first_retire got rv=%b fl=%b exp rv=111 fl=0", bus.retire_valid, bus.flush_valid); end
        tick();
        drive_idle();
        bus.dispatch_valid = 3'b111;
        rand_data();
        model_eval();
        checks++; if (bus.retire_valid !== 3'b011) begin failures++; $display("FAIL mp_retire got=%b exp=011", bus.retire_valid); end
        checks++; if (bus.retire_idx !== e_ridx) begin failures++; $display("FAIL mp_retire_idx got=%h exp=%h", bus.retire_idx, e_ridx); end
        checks++; if (bus.flush_valid !== 1'b1) begin failures++; $display("FAIL mp_flush_valid got=%b exp=1", bus.flush_valid); end
        checks++; if (bus.flush_target !== 32'h0000_1000) begin failures++; $display("FAIL mp_flush_target got=%h exp=00001000", bus.flush_target); end
        checks++; if (bus.dispatch_stall !== 3'b111) begin failures++; $display("FAIL mp_stall got=%b exp=111", bus.dispatch_stall); end
        tick();
        drive_idle();
        model_eval();
        checks++; if (bus.occupancy !== 6'd0) begin failures++; $display("FAIL mp_after_flush got=%0d exp=0", bus.occupancy); end
        checks++; if (bus.flush_target !== 32'h0) begin failures++; $display("FAIL mp_target_idle got=%h exp=0", bus.flush_target); end
    endtask

    task automatic test_wrap();
        int sent;
        drive_idle();
        bus.ext_flush = 1'b1;
        model_eval();
        tick();
        sent = 0;
        for (int c = 0; c < 40 && !(sent == 30 && q.size() == 0); c++) begin
            drive_idle();
            if (sent < 30) begin bus.dispatch_valid = 3'b111; rand_data(); end
            auto_complete();
            model_eval();
            sent += e_nacc;
            tick();
        end
        drive_idle();
        bus.dispatch_valid = 3'b111;
        rand_data();
        model_eval();
        checks++; if (bus.occupancy !== 6'd0) begin failures++; $display("FAIL wrap_setup_occ got=%0d exp=0", bus.occupancy); end
        checks++; if (bus.dispatch_index !== {5'd0, 5'd31, 5'd30}) begin failures++; $display("FAIL wrap_idx got=%h exp=%h", bus.dispatch_index, {5'd0, 5'd31, 5'd30}); end
        tick();
        for (int c = 0; c < 6; c++) begin
            drive_idle();
            bus.dispatch_valid = 3'b111;
            rand_data();
            if (c < 4) auto_complete();
            model_eval();
            checks++; if (bus.retire_idx !== e_ridx || bus.retire_valid !== e_rv) begin
                failures++; $display("FAIL wrap_retire c=%0d got v=%b i=%h exp v=%b i=%h", c, bus.retire_valid, bus.retire_idx, e_rv, e_ridx); end
            tick();
        end
        drive_idle();
        auto_complete();
        bus.ext_flush = 1'b1;
        model_eval();
        tick();
        drive_idle();
        model_eval();
        checks++; if (bus.occupancy !== 6'd0 || bus.retire_valid !== 3'b000) begin
            failures++; $display("FAIL wrap_ext_flush got occ=%0d rv=%b exp occ=0 rv=000", bus.occupancy, bus.retire_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int n;
            drive_idle();
            n = $urandom_range(0, 3);
            bus.dispatch_valid = DISPATCH_W'((1 << n) - 1);
            rand_data();
            for (int p = 0; p < COMPLETE_W; p++) begin
                int idx;
                if (q.size() > 0 && $urandom_range(0, 4) != 0) idx = q[$urandom_range(0, q.size() - 1)].slot;
                else idx = $urandom_range(0, DEPTH - 1);
                bus.complete_valid[p] = ($urandom_range(0, 9) < 6);
                bus.complete_idx[p*IW +: IW] = IW'(idx);
                bus.complete_mispred[p] = ($urandom_range(0, 24) == 0);
                bus.complete_target[p*XLEN +: XLEN] = $urandom;
            end
            bus.ext_flush = ($urandom_range(0, 99) == 0);
            model_eval();
            checks++; if (bus.retire_valid !== e_rv) begin failures++; $display("FAIL rnd_retire_valid c=%0d got=%b exp=%b", c, bus.retire_valid, e_rv); end
            checks++; if (bus.retire_idx !== e_ridx) begin failures++; $display("FAIL rnd_retire_idx c=%0d got=%h exp=%h", c, bus.retire_idx, e_ridx); end
            checks++; if (bus.retire_data !== e_rdata) begin failures++; $display("FAIL rnd_retire_data c=%0d got=%h exp=%h", c, bus.retire_data, e_rdata); end
            checks++; if (bus.flush_valid !== e_fl || bus.flush_target !== e_ft) begin
                failures++; $display("FAIL rnd_flush c=%0d got=%b/%h exp=%b/%h", c, bus.flush_valid, bus.flush_target, e_fl, e_ft); end
            checks++; if (bus.dispatch_stall !== e_stall || bus.dispatch_index !== e_didx) begin
                failures++; $display("FAIL rnd_dispatch c=%0d got=%b/%h exp=%b/%h", c, bus.dispatch_stall, bus.dispatch_index, e_stall, e_didx); end
            checks++; if (bus.occupancy !== e_occ) begin failures++; $display("FAIL rnd_occupancy c=%0d got=%0d exp=%0d", c, bus.occupancy, e_occ); end
            tick();
        end
        drive_idle();
        model_eval();
`ifdef ROB_PERF_CNT_EN
        checks++; if (bus.perf_retired !== 32'(m_retired)) begin failures++; $display("FAIL perf_retired got=%0d exp=%0d", bus.perf_retired, m_retired); end
        checks++; if (bus.perf_full_cycles !== 32'(m_full)) begin failures++; $display("FAIL perf_full_rnd got=%0d exp=%0d", bus.perf_full_cycles, m_full); end
`endif
    endtask

    task automatic test_midreset();
        for (int c = 0; c < 2; c++) begin
            drive_idle();
            bus.dispatch_valid = 3'b111;
            rand_data();
            model_eval();
            tick();
        end
        drive_idle();
        auto_complete();
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        drive_idle();
        q.delete(); m_tail = 0; m_retired = 0; m_full = 0;
        model_eval();
        checks++; if (bus.occupancy !== 6'd0 || bus.retire_valid !== 3'b000) begin
            failures++; $display("FAIL midreset got occ=%0d rv=%b exp occ=0 rv=000", bus.occupancy, bus.retire_valid); end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_fill();
        test_complete_retire();
        test_out_of_order();
        test_mispred();
        test_wrap();
        test_random();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
